// File: rtl/arm_pipe_chain.sv
// Elastic DEPTH-stage pipeline register chain with ready/valid backpressure,
// bubble collapsing and leading-stage flush. Option: ARM_PIPE_CHAIN_ZERO_BUBBLE_EN.
module arm_pipe_chain #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter int FLUSH_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_reg;
  logic [DEPTH-1:0] v_next;
  logic [WIDTH-1:0] d_reg  [DEPTH];
  logic [WIDTH-1:0] d_next [DEPTH];
  logic [DEPTH:0]   adv;

  assign adv[DEPTH] = out_ready;
  assign in_ready   = !flush && adv[0];
  assign out_valid  = v_reg[DEPTH-1];
  assign out_data   = d_reg[DEPTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             src_v;
      logic [WIDTH-1:0] src_d;
      logic             kill;
      logic             cut;

      // A stage may load whenever it is empty or its word moves on.
      assign adv[gi] = !v_reg[gi] || adv[gi+1];

      if (gi == 0) begin : g_src_in
        assign src_v = in_valid && in_ready;
        assign src_d = in_data;
      end else begin : g_src_prev
        assign src_v = v_reg[gi-1];
        assign src_d = d_reg[gi-1];
      end

      if (gi < FLUSH_STAGES) begin : g_kill
        assign kill = flush;
      end else begin : g_nokill
        assign kill = 1'b0;
      end

      // The first surviving stage must not pick up a word that is being killed.
      if (gi == FLUSH_STAGES) begin : g_cut
        assign cut = flush;
      end else begin : g_nocut
        assign cut = 1'b0;
      end

      assign v_next[gi] = kill ? 1'b0 :
                          adv[gi] ? (src_v && !cut) : v_reg[gi];

`ifdef ARM_PIPE_CHAIN_ZERO_BUBBLE_EN
      assign d_next[gi] = !v_next[gi] ? '0 :
                          adv[gi] ? src_d : d_reg[gi];
`else
      assign d_next[gi] = adv[gi] ? src_d : d_reg[gi];
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_reg[i] <= '0;
      end
    end else begin
      v_reg <= v_next;
      for (int i = 0; i < DEPTH; i++) begin
        d_reg[i] <= d_next[i];
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OW'(v_reg[i]);
    end
  end

endmodule

// File: tb/tb_arm_pipe_chain.sv
// Bench for arm_pipe_chain: vector table plus hand sequences for flush and async reset,
// two instances (FLUSH_STAGES=2 and FLUSH_STAGES=DEPTH) sharing stimulus.
module tb_arm_pipe_chain;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_ready = 1'b0;
  logic             flush = 1'b0;

  logic             a_ir, a_ov, b_ir, b_ov;
  logic [WIDTH-1:0] a_od, b_od;
  logic [2:0]       a_occ, b_occ;

  int checks = 0;
  int errors = 0;
  int a_deliv = 0;
  int b_deliv = 0;
  logic [WIDTH-1:0] sb_q [$];

  typedef struct {
    bit               rst_first;
    bit               iv;
    logic [WIDTH-1:0] d;
    bit               ordy;
    bit               ir;
    bit               ov;
    int               occ;
  } vec_t;
  vec_t vecs [$];

  always #5 clk = ~clk;

  arm_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FLUSH_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ir), .in_data(in_data),
    .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .flush(flush),
    .occupancy(a_occ)
  );

  arm_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FLUSH_STAGES(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ir), .in_data(in_data),
    .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .flush(flush),
    .occupancy(b_occ)
  );

  task automatic chk(input string name, input int idx, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  // Scoreboard on instance A: pop before push so a same-edge pass-through is ordered.
  always @(posedge clk) begin
    if (!rst) begin
      if (a_ov && out_ready) begin
        a_deliv++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra actual=%h required=none", a_od);
        end else begin
          logic [WIDTH-1:0] exp_w;
          exp_w = sb_q.pop_front();
          if (a_od !== exp_w) begin
            errors++;
            $display("FAIL sb_data actual=%h required=%h", a_od, exp_w);
          end else begin
            $display("OUT  data=%h", a_od);
          end
        end
      end
      if (in_valid && a_ir) begin
        sb_q.push_back(in_data);
        $display("IN   data=%h", in_data);
      end
      if (b_ov && out_ready) b_deliv++;
    end
  end

  function automatic void add(bit r, bit iv, logic [WIDTH-1:0] d, bit ordy,
                              bit ir, bit ov, int occ);
    vec_t v;
    v.rst_first = r; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.occ = occ;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_ov", 0, {31'd0, a_ov}, 0);
    chk("rst_occ", 0, {29'd0, a_occ}, 0);
    chk("rst_od", 0, a_od, 0);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    #1;
    chk("rst_ir", 0, {31'd0, a_ir}, 1);
  endtask

  task automatic drive(input bit iv, input logic [WIDTH-1:0] d, input bit ordy, input bit fl);
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_a, base_b, n;

    // Reset then stream with out_ready held high.
    add(1, 1, 32'h10, 1, 1, 0, 0);
    add(0, 1, 32'h11, 1, 1, 0, 1);
    add(0, 1, 32'h12, 1, 1, 0, 2);
    add(0, 1, 32'h13, 1, 1, 0, 3);
    add(0, 1, 32'h14, 1, 1, 1, 4);
    add(0, 1, 32'h15, 1, 1, 1, 4);
    add(0, 0, 32'h0,  1, 1, 1, 4);
    add(0, 0, 32'h0,  1, 1, 1, 3);
    add(0, 0, 32'h0,  1, 1, 1, 2);
    add(0, 0, 32'h0,  1, 1, 1, 1);
    add(0, 0, 32'h0,  1, 1, 0, 0);
    // Backpressure: fill, full stall, one-cycle pass-through, drain.
    add(1, 1, 32'hA0, 0, 1, 0, 0);
    add(0, 1, 32'hA1, 0, 1, 0, 1);
    add(0, 1, 32'hA2, 0, 1, 0, 2);
    add(0, 1, 32'hA3, 0, 1, 0, 3);
    add(0, 1, 32'hA4, 0, 0, 1, 4);
    add(0, 1, 32'hA4, 1, 1, 1, 4);
    add(0, 0, 32'h0,  0, 0, 1, 4);
    add(0, 0, 32'h0,  1, 1, 1, 4);
    add(0, 0, 32'h0,  1, 1, 1, 3);
    add(0, 0, 32'h0,  1, 1, 1, 2);
    add(0, 0, 32'h0,  1, 1, 1, 1);
    add(0, 0, 32'h0,  1, 1, 0, 0);
    // Bubble collapse under a stalled output.
    add(1, 1, 32'hD0, 0, 1, 0, 0);
    add(0, 0, 32'h0,  0, 1, 0, 1);
    add(0, 1, 32'hD1, 0, 1, 0, 1);
    add(0, 0, 32'h0,  0, 1, 0, 2);
    add(0, 0, 32'h0,  0, 1, 1, 2);
    add(0, 0, 32'h0,  0, 1, 1, 2);
    add(0, 0, 32'h0,  0, 1, 1, 2);
    add(0, 0, 32'h0,  1, 1, 1, 2);
    add(0, 0, 32'h0,  1, 1, 1, 1);
    add(0, 0, 32'h0,  1, 1, 0, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0);
      chk("vec_ir", i, {31'd0, a_ir}, {31'd0, vecs[i].ir});
      chk("vec_ov", i, {31'd0, a_ov}, {31'd0, vecs[i].ov});
      chk("vec_occ", i, {29'd0, a_occ}, vecs[i].occ);
    end

    // Flush of two leading stages with the output stalled.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'hB0 + i, 1'b0, 1'b0);
    drive(1'b1, 32'hBF, 1'b0, 1'b1);
    chk("flush_ir_a", 0, {31'd0, a_ir}, 0);
    chk("flush_ir_b", 0, {31'd0, b_ir}, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    void'(sb_q.pop_back());
    void'(sb_q.pop_back());
    chk("flush_occ_a", 0, {29'd0, a_occ}, 2);
    chk("flush_ov_a", 0, {31'd0, a_ov}, 1);
    chk("flush_occ_b", 0, {29'd0, b_occ}, 0);
    chk("flush_ov_b", 0, {31'd0, b_ov}, 0);
    base_a = a_deliv;
    n = 0;
    out_ready = 1'b1;
    while (a_ov && n < 10) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("flush_drain_ov", 0, {31'd0, a_ov}, 0);
    chk("flush_deliv", 0, a_deliv - base_a, 2);

    // Full flush while the head word is being taken.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'hE0 + i, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("fo_ov_b", 0, {31'd0, b_ov}, 1);
    chk("fo_od_b", 0, b_od, 32'hE0);
    chk("fo_ir_b", 0, {31'd0, b_ir}, 0);
    base_b = b_deliv;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    void'(sb_q.pop_back());
    void'(sb_q.pop_back());
    chk("fo_deliv_b", 0, b_deliv - base_b, 1);
    chk("fo_occ_b", 0, {29'd0, b_occ}, 0);
    chk("fo_ov_b2", 0, {31'd0, b_ov}, 0);
    chk("fo_occ_a", 0, {29'd0, a_occ}, 1);
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fo_deliv_b2", 0, b_deliv - base_b, 1);
    chk("fo_occ_a2", 0, {29'd0, a_occ}, 0);

    // Asynchronous reset between edges, then normal latency afterwards.
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h30 + i, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("ar_pre_occ", 0, {29'd0, a_occ}, 3);
    chk("ar_pre_ov", 0, {31'd0, a_ov}, 1);
    #1 rst = 1'b1;
    #1;
    chk("ar_occ", 0, {29'd0, a_occ}, 0);
    chk("ar_ov", 0, {31'd0, a_ov}, 0);
    chk("ar_od", 0, a_od, 0);
    #1 rst = 1'b0;
    sb_q.delete();
    drive(1'b1, 32'hC0, 1'b1, 1'b0);
    chk("ar_ir", 0, {31'd0, a_ir}, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      #2;
      n++;
      if (a_ov) break;
    end
    chk("ar_latency", 0, n, 4);
    chk("ar_od_c0", 0, a_od, 32'hC0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("sb_empty", 0, sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
